// File: rtl/dense_acc_requant_pkg.sv
// Shared definitions for the dense-layer accumulate/requantise stage.
// Build option: define DENSE_ACC_RELU_EN to clamp negative results to zero.
package dense_acc_requant_pkg;

    localparam int DEF_PROD_W = 29;
    localparam int DEF_N_TAPS = 9;
    localparam int DEF_CNT_W  = 4;
    localparam int DEF_ACC_W  = 34;
    localparam int DEF_BIAS_W = 16;
    localparam int DEF_OUT_W  = 16;
    localparam int DEF_SHIFT  = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    typedef logic signed [DEF_ACC_W-1:0] acc_t;

endpackage

// File: rtl/dense_acc_requant_sat.sv
// Round-half-up, arithmetic shift and clip of a wide accumulator to OUT_W signed.
// Latency: combinational. Backpressure: none.
// Build option: DENSE_ACC_RELU_EN maps negative results to zero (not flagged as saturation).
module dense_acc_requant_sat #(
    parameter int ACC_W = 34,
    parameter int OUT_W = 16,
    parameter int SHIFT = 12
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [OUT_W-1:0] q_dat,
    output logic                    q_sat
);

    localparam logic signed [ACC_W-1:0] HALF = {{(ACC_W-1){1'b0}}, 1'b1} << (SHIFT-1);
    localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV = ~MAXV;

    logic signed [ACC_W-1:0] rnd;
    logic signed [ACC_W-1:0] r;

    always_comb begin
        rnd   = acc + HALF;
        r     = rnd >>> SHIFT;
        q_dat = r[OUT_W-1:0];
        q_sat = 1'b0;
        if (r > MAXV) begin
            q_dat = MAXV[OUT_W-1:0];
            q_sat = 1'b1;
`ifdef DENSE_ACC_RELU_EN
        end else if (r < 0) begin
            q_dat = '0;
            q_sat = 1'b0;
`else
        end else if (r < MINV) begin
            q_dat = MINV[OUT_W-1:0];
            q_sat = 1'b1;
`endif
        end
    end

endmodule

// File: rtl/dense_acc_requant.sv
// Sums N_TAPS signed products onto a per-output bias, requantises to OUT_W signed.
// Latency: result registered on the edge of the last product beat; one bubble per group.
// Backpressure: prod_rdy low while a result waits for out_rdy (DENSE_ACC_RELU_EN: ReLU output).
module dense_acc_requant
    import dense_acc_requant_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int N_TAPS = DEF_N_TAPS,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int BIAS_W = DEF_BIAS_W,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int SHIFT  = DEF_SHIFT
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic signed [BIAS_W-1:0] bias,
    input  logic signed [PROD_W-1:0] prod_dat,
    input  logic                     prod_vld,
    output logic                     prod_rdy,
    output logic signed [OUT_W-1:0]  out_dat,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic                     out_sat
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TAPS-1);

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] base;
    logic signed [ACC_W-1:0] sum;
    logic signed [OUT_W-1:0] q_dat;
    logic                    q_sat;
    logic                    beat;

    assign beat = prod_vld & prod_rdy;

    // The first beat of a group starts from the bias, aligned to the product LSB weight.
    always_comb begin
        base = acc;
        if (state == IDLE)
            base = {{(ACC_W-BIAS_W){bias[BIAS_W-1]}}, bias} << SHIFT;
        sum = base + {{(ACC_W-PROD_W){prod_dat[PROD_W-1]}}, prod_dat};
    end

    dense_acc_requant_sat #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_sat (
        .acc   (sum),
        .q_dat (q_dat),
        .q_sat (q_sat)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            prod_rdy <= 1'b0;
            out_vld  <= 1'b0;
            out_dat  <= '0;
            out_sat  <= 1'b0;
        end else begin
            case (state)
                IDLE, ACC: begin
                    prod_rdy <= 1'b1;
                    if (beat) begin
                        acc <= sum;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST) begin
                            state    <= OUT;
                            prod_rdy <= 1'b0;
                            out_vld  <= 1'b1;
                            out_dat  <= q_dat;
                            out_sat  <= q_sat;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                OUT: begin
                    if (out_rdy) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        out_vld  <= 1'b0;
                        prod_rdy <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    out_vld  <= 1'b0;
                    prod_rdy <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dense_acc_requant.sv
// Bench for dense_acc_requant: directed vector table, backpressure/reset sequences, random groups vs model.
module tb_dense_acc_requant;

    logic               ap_clk = 1'b0;
    logic               ap_rst_n;
    logic signed [15:0] bias;
    logic signed [28:0] prod_dat;
    logic               prod_vld;
    logic               prod_rdy;
    logic signed [15:0] out_dat;
    logic               out_vld;
    logic               out_rdy;
    logic               out_sat;

    int n_checks = 0;
    int n_err    = 0;

    logic signed [15:0] cur_bias;
    logic signed [28:0] cur_prod [9];

    always #5 ap_clk = ~ap_clk;

    dense_acc_requant dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bias     (bias),
        .prod_dat (prod_dat),
        .prod_vld (prod_vld),
        .prod_rdy (prod_rdy),
        .out_dat  (out_dat),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_sat  (out_sat)
    );

    typedef struct {
        string              nm;
        logic signed [15:0] b;
        logic signed [28:0] p0;
        logic signed [28:0] pr;
        longint             ed;
        logic               es;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Reference: exact sum in 64-bit integers, floor((s + half)/2^12), then clip.
    function automatic logic [16:0] model();
        longint s;
        longint r;
        s = longint'(cur_bias) * 4096;
        for (int i = 0; i < 9; i++) s += longint'(cur_prod[i]);
        r = (s + 2048) >>> 12;
        if (r > 32767) return {1'b1, 16'h7fff};
`ifdef DENSE_ACC_RELU_EN
        if (r < 0) return {1'b0, 16'h0000};
`else
        if (r < -32768) return {1'b1, 16'h8000};
`endif
        return {1'b0, 16'(r)};
    endfunction

    task automatic feed_beats(input int n, input int gap_pct);
        int i = 0;
        int guard = 0;
        while (i < n && guard < 2000) begin
            @(negedge ap_clk);
            guard++;
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                prod_vld = 1'b0;
                prod_dat = 29'($urandom);
            end else begin
                prod_vld = 1'b1;
                prod_dat = cur_prod[i];
            end
            bias = (i == 0) ? cur_bias : 16'($urandom);
            if (prod_vld && prod_rdy) begin
                if (i == 8) chk("vld_before_last_beat", out_vld, 0);
                i++;
            end
        end
        if (i < n) chk("beat_timeout", i, n);
    endtask

    task automatic run_group(input int gap_pct, input int hold,
                             output logic signed [15:0] gd, output logic gs);
        feed_beats(9, gap_pct);
        @(negedge ap_clk);
        prod_vld = 1'b0;
        chk("vld_after_last_beat", out_vld, 1);
        gd = out_dat;
        gs = out_sat;
        for (int k = 0; k < hold; k++) begin
            prod_vld = k[0];
            prod_dat = 29'($urandom);
            @(negedge ap_clk);
            chk("hold_vld", out_vld, 1);
            chk("hold_rdy_low", prod_rdy, 0);
            chk("hold_dat_stable", out_dat, gd);
            chk("hold_sat_stable", out_sat, gs);
        end
        prod_vld = 1'b0;
        out_rdy  = 1'b1;
        @(negedge ap_clk);
        out_rdy = 1'b0;
        chk("vld_drop_after_rdy", out_vld, 0);
        chk("rdy_back_after_out", prod_rdy, 1);
    endtask

    task automatic do_reset();
        @(negedge ap_clk);
        ap_rst_n = 1'b0;
        #1;
        chk("rst_prod_rdy", prod_rdy, 0);
        chk("rst_out_vld", out_vld, 0);
        chk("rst_out_dat", out_dat, 0);
        chk("rst_out_sat", out_sat, 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        @(negedge ap_clk);
        chk("rdy_after_rst", prod_rdy, 1);
    endtask

    initial begin
        logic signed [15:0] gd;
        logic               gs;
        logic [16:0]        m;

        tbl[0] = '{"basic",     16'sd0,  29'sd4096,     29'sd4096,     9,  1'b0};
        tbl[1] = '{"rnd_2048",  16'sd0,  29'sd2048,     29'sd0,        1,  1'b0};
        tbl[2] = '{"rnd_2047",  16'sd0,  29'sd2047,     29'sd0,        0,  1'b0};
        tbl[3] = '{"rnd_m2048", 16'sd0, -29'sd2048,     29'sd0,        0,  1'b0};
`ifdef DENSE_ACC_RELU_EN
        tbl[4] = '{"rnd_m2049", 16'sd0, -29'sd2049,     29'sd0,        0,  1'b0};
        tbl[6] = '{"sat_neg",   16'sd0,  29'h1000_0000, 29'h1000_0000, 0,  1'b0};
        tbl[7] = '{"bias_neg",  -16'sd5, 29'sd4096,     29'sd4096,     4,  1'b0};
`else
        tbl[4] = '{"rnd_m2049", 16'sd0, -29'sd2049,     29'sd0,        -1, 1'b0};
        tbl[6] = '{"sat_neg",   16'sd0,  29'h1000_0000, 29'h1000_0000, -32768, 1'b1};
        tbl[7] = '{"bias_neg",  -16'sd5, 29'sd4096,     29'sd4096,     4,  1'b0};
`endif
        tbl[5] = '{"sat_pos",   16'sd0,  29'h07FF_FFFF, 29'h07FF_FFFF, 32767, 1'b1};

        ap_rst_n = 1'b0;
        bias     = '0;
        prod_dat = '0;
        prod_vld = 1'b0;
        out_rdy  = 1'b0;
        do_reset();

        for (int v = 0; v < 8; v++) begin
            cur_bias    = tbl[v].b;
            cur_prod[0] = tbl[v].p0;
            for (int i = 1; i < 9; i++) cur_prod[i] = tbl[v].pr;
            run_group(0, (v == 7) ? 5 : 0, gd, gs);
            chk({tbl[v].nm, "_dat"}, gd, tbl[v].ed);
            chk({tbl[v].nm, "_sat"}, gs, tbl[v].es);
        end

        // Gapped input: 1..9 x 4096 sums to 45.
        cur_bias = 16'sd0;
        for (int i = 0; i < 9; i++) cur_prod[i] = 29'(4096 * (i + 1));
        run_group(40, 2, gd, gs);
        chk("gapped_dat", gd, 45);
        chk("gapped_sat", gs, 0);

        // Reset after four beats of a group.
        for (int i = 0; i < 9; i++) cur_prod[i] = 29'sd4096;
        feed_beats(4, 0);
        @(negedge ap_clk);
        prod_vld = 1'b0;
        #2 ap_rst_n = 1'b0;
        #1 chk("midgrp_rst_vld", out_vld, 0);
        chk("midgrp_rst_rdy", prod_rdy, 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        run_group(0, 0, gd, gs);
        chk("after_midrst_dat", gd, 9);

        // Reset while a result is pending.
        feed_beats(9, 0);
        @(negedge ap_clk);
        prod_vld = 1'b0;
        chk("pending_vld", out_vld, 1);
        #2 ap_rst_n = 1'b0;
        #1 chk("outstate_rst_vld", out_vld, 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        run_group(0, 0, gd, gs);
        chk("after_outrst_dat", gd, 9);
        chk("after_outrst_sat", gs, 0);

        // Random groups against the reference model.
        for (int g = 0; g < 30; g++) begin
            cur_bias = 16'($urandom);
            for (int i = 0; i < 9; i++) begin
                if (g < 10) cur_prod[i] = 29'($urandom);
                else cur_prod[i] = 29'($urandom_range(0, 2 * 65536)) - 29'sd65536;
            end
            m = model();
            run_group(30, $urandom_range(0, 3), gd, gs);
            chk("rand_dat", gd, longint'($signed(m[15:0])));
            chk("rand_sat", gs, m[16]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
